// File: rtl/voice_mixer.sv
// voice_mixer: time-multiplexed sum of NUM_VOICES samples, then gain shift and saturation.
module voice_mixer #(
  parameter int NUM_VOICES    = 8,
  parameter int NUM_BITS_WORD = 18,
  parameter int SHIFT_BITS    = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sample_tick,
  input  logic [NUM_VOICES*NUM_BITS_WORD-1:0] voice_word,
  input  logic [NUM_VOICES-1:0]               voice_avail,
  input  logic [SHIFT_BITS-1:0]               gain_shift,
  input  logic                                clr_flags,
  output logic [NUM_BITS_WORD-1:0]            mix_out,
  output logic                                mix_valid,
  input  logic                                mix_ready,
  output logic                                busy,
  output logic                                clip,
  output logic                                overrun
);
  localparam int W     = NUM_BITS_WORD;
  localparam int IW    = $clog2(NUM_VOICES);
  localparam int ACC_W = W + IW + 1;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (W - 1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, HOLD} state_t;
  state_t state, state_d;
  logic [W-1:0] words_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] avail_q;
  logic [SHIFT_BITS-1:0] shift_q;
  logic signed [ACC_W-1:0] acc, ext, scaled;
  logic [IW-1:0] idx;
  logic hi, lo;
  logic [W-1:0] sat;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state == IDLE  ? (sample_tick ? ACCUM : IDLE) :
              state == ACCUM ? (idx == LAST ? SCALE : ACCUM) :
              state == SCALE ? HOLD : (mix_ready ? IDLE : HOLD);
    ext     = {{(ACC_W - W){words_q[idx][W-1]}}, words_q[idx]};
    scaled  = acc >>> shift_q;
    hi      = scaled > MAX_V;
    lo      = scaled < MIN_V;
    sat     = hi ? MAX_V[W-1:0] : lo ? MIN_V[W-1:0] : scaled[W-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end
  // Flags use set-over-clear priority so a coincident event is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VOICES; i++) words_q[i] <= '0;
      avail_q   <= '0;
      shift_q   <= '0;
      acc       <= '0;
      idx       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state == IDLE && sample_tick) begin
        for (int i = 0; i < NUM_VOICES; i++) words_q[i] <= voice_word[i*W +: W];
        avail_q <= voice_avail;
        shift_q <= gain_shift;
        acc     <= '0;
        idx     <= '0;
      end
      if (state == ACCUM) begin
        acc <= avail_q[idx] ? acc : acc + ext;
        idx <= idx + 1'b1;
      end
      if (state == SCALE) begin
        mix_out   <= sat;
        mix_valid <= 1'b1;
      end
      if (state == HOLD && mix_ready) mix_valid <= 1'b0;
      clip    <= (state == SCALE && (hi || lo)) | (clip & ~clr_flags);
      overrun <= (sample_tick && state != IDLE) | (overrun & ~clr_flags);
    end
  end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed scoreboard bench for voice_mixer.
module tb_voice_mixer;
  localparam int N = 8;
  localparam int W = 18;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_tick = 1'b0;
  logic [N*W-1:0] voice_word = '0;
  logic [N-1:0] voice_avail = '0;
  logic [2:0] gain_shift = '0;
  logic clr_flags = 1'b0;
  logic [W-1:0] mix_out;
  logic mix_valid;
  logic mix_ready = 1'b0;
  logic busy, clip, overrun;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {logic [W-1:0] o; logic c;} exp_t;
  exp_t sb[$];

  voice_mixer #(.NUM_VOICES(N), .NUM_BITS_WORD(W), .SHIFT_BITS(3)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .voice_word(voice_word),
    .voice_avail(voice_avail), .gain_shift(gain_shift), .clr_flags(clr_flags),
    .mix_out(mix_out), .mix_valid(mix_valid), .mix_ready(mix_ready),
    .busy(busy), .clip(clip), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge where mix_valid is seen
  // (or, with mix_ready=1, one cycle later after checking the valid dropped).
  task automatic run_sample(input string tag, input logic [N*W-1:0] words, input logic [N-1:0] avail,
                            input logic [2:0] sh, input logic [W-1:0] e_out, input logic e_clip,
                            input bit scramble);
    int lat;
    exp_t e;
    voice_word = words;
    voice_avail = avail;
    gain_shift = sh;
    sample_tick = 1'b1;
    sb.push_back('{e_out, e_clip});
    @(negedge clk);
    sample_tick = 1'b0;
    lat = 1;
    if (scramble) begin
      voice_word = ~words;
      voice_avail = ~avail;
      gain_shift = sh + 3'd1;
    end
    while (!mix_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd10);
    if (mix_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_mix_out"}, 64'(mix_out), 64'(e.o));
      chk({tag, "_clip"}, 64'(clip), 64'(e.c));
    end
    if (mix_ready) begin
      @(negedge clk);
      chk({tag, "_valid_drop"}, 64'({mix_valid, busy}), 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] held;
    bit ok;
    // reset held with random stimulus
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample_tick = 1'($urandom);
      voice_avail = N'($urandom);
      gain_shift = 3'($urandom);
      mix_ready = 1'($urandom);
      clr_flags = 1'($urandom);
      voice_word[31:0] = $urandom;
      #1;
      chk("reset_outputs", 64'({mix_out, mix_valid, busy, clip, overrun}), 64'd0);
    end
    @(negedge clk);
    sample_tick = 1'b0;
    clr_flags = 1'b0;
    mix_ready = 1'b0;
    voice_word = '0;
    voice_avail = '0;
    gain_shift = '0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_no_tick", 64'({busy, mix_valid}), 64'd0);
    end
    mix_ready = 1'b1;
    run_sample("sum8", {N{18'h00100}}, 8'h00, 3'd0, 18'h00800, 1'b0, 0);
    chk("no_overrun", 64'(overrun), 64'd0);
    run_sample("pos_sat", {N{18'h1FFFF}}, 8'h00, 3'd0, 18'h1FFFF, 1'b1, 0);
    pulse_clr();
    chk("clip_cleared", 64'(clip), 64'd0);
    run_sample("neg_sat", {N{18'h20000}}, 8'h00, 3'd0, 18'h20000, 1'b1, 0);
    pulse_clr();
    run_sample("pos_shift3", {N{18'h1FFFF}}, 8'h00, 3'd3, 18'h1FFFF, 1'b0, 0);
    run_sample("neg_shift3", {N{18'h20000}}, 8'h00, 3'd3, 18'h20000, 1'b0, 0);
    run_sample("avail_mask", {{4{18'h10000}}, {4{18'h00010}}}, 8'hF0, 3'd0, 18'h00040, 1'b0, 0);
    run_sample("snapshot", {{4{18'h10000}}, {4{18'h00010}}}, 8'hF0, 3'd0, 18'h00040, 1'b0, 1);
    run_sample("all_free", {N{18'h12345}}, 8'hFF, 3'd0, 18'h00000, 1'b0, 0);
    // backpressure in HOLD, with a dropped tick
    mix_ready = 1'b0;
    run_sample("hold", {N{18'h00100}}, 8'h00, 3'd0, 18'h00800, 1'b0, 0);
    held = mix_out;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok &= (mix_out === held) && (mix_valid === 1'b1);
      sample_tick = (i == 5);
    end
    sample_tick = 1'b0;
    chk("hold_stable", 64'(ok), 64'd1);
    chk("hold_overrun", 64'(overrun), 64'd1);
    chk("hold_busy", 64'(busy), 64'd1);
    pulse_clr();
    chk("overrun_cleared", 64'(overrun), 64'd0);
    mix_ready = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("ready_tick_idle", 64'({mix_valid, busy}), 64'd0);
    chk("ready_tick_overrun", 64'(overrun), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ok &= !mix_valid && !busy;
    end
    chk("dropped_no_sample", 64'(ok), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    pulse_clr();
    // async reset during the 4th ACCUM cycle
    voice_word = {N{18'h00100}};
    voice_avail = '0;
    gain_shift = '0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_outputs", 64'({mix_out, mix_valid, busy, clip, overrun}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ok &= !mix_valid;
    end
    chk("abort_no_valid", 64'(ok), 64'd1);
    run_sample("after_abort", {{4{18'h00020}}, {4{18'h3FFFF}}}, 8'h0F, 3'd0, 18'h00080, 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
